priority_enc_rr: RTL and testbench
==================================

# priority_enc_rr

Parametrised, registered N-input priority encoder with two selectable arbitration modes, fixed priority and round-robin, and a valid/ready output handshake. It is the next generation of the team's 4-input registered priority encoder. It keeps that block's slot convention (slot 0 = MSB of `D`) and adds width generalisation, a one-hot grant vector, a multi-request flag, and output backpressure. It sits between a bank of request lines and a single downstream consumer that accepts one encoded winner per handshake.

## Interface
- `N`, default 8: number of request inputs; legal range 2..32; need not be a power of two.
- `W`, default `$clog2(N)`: index width; derived, not to be overridden.
- `clk` input 1: sole clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-low reset (asserted when 0, sampled on the rising edge of `clk`).
- `D` input N: request vector; slot i corresponds to `D[N-1-i]`.
- `mode` input 1: 0 = fixed priority (slot 0 highest), 1 = round-robin.
- `out_ready` input 1: consumer can accept the presented result.
- `Y` output W: encoded winning slot index.
- `onehot` output N: copy of `D` with only the winning bit set; all zero when no request.
- `multi` output 1: more than one bit of `D` was set when the result was loaded.
- `out_valid` output 1: `Y`/`onehot`/`multi` hold a result with at least one request.

## Operation
- **Output register:** `Y`, `onehot`, `multi`, `out_valid` form one register stage.
- **Load condition:** load = `!out_valid || out_ready`. On load, `D` is sampled that cycle. `D` need not be held by the source.
- **D = 0 on load:** `Y`=0, `onehot`=0, `multi`=0, `out_valid`=0.
- **D ≠ 0 on load:** `out_valid`=1. `Y` = winning slot, `onehot` = that bit only. `multi` = (popcount(`D`) > 1).
- **No load:** all outputs hold, regardless of `D` or `mode` changes.
- **Fixed mode:** winner = lowest-numbered slot with its request set.
- **Round-robin mode:**
  - Internal pointer `ptr` (W bits).
  - Winner = first requesting slot scanning ptr, ptr+1, …, N-1, 0, …, ptr-1 (wrap at N-1 → 0, including non-power-of-2 N).
- **Accept:** `out_valid && out_ready`.
  - In mode 1, on accept: `ptr` <= (`Y` == N-1) ? 0 : `Y`+1.
  - In mode 0, `ptr` holds.
- **Simultaneous accept and load:**
  - The new load uses the effective pointer: the updated value if an accept occurs that cycle, else `ptr`.
  - A continuously requesting set therefore rotates every cycle.
- **Mode change:** takes effect at the next load. `ptr` is retained across mode changes.
- **Reset:**
  - Dominates load and accept.
  - Reset values: `Y`=0, `onehot`=0, `multi`=0, `out_valid`=0, `ptr`=0.
  - A result pending at reset is discarded.

## Timing
- **Latency:** 1 cycle from `D` sampled (load edge) to the result visible on outputs.
- **Throughput:** 1 result/cycle while `out_ready`=1.
- **Backpressure:**
  - With `out_valid`=1 and `out_ready`=0, outputs are frozen.
  - The first cycle with `out_ready`=1 accepts and loads the then-current `D` in the same edge.
- **After reset release:** the first rising edge with `rst`=1 is a load (since `out_valid`=0).
- **Ready dependency:** no combinational path from `out_ready` to any output. Outputs are all register-driven.

## Test plan
N=8 throughout.
- **Reset:** `rst`=0 for 2 cycles with `D`=8'hFF, `out_ready`=1 -> `out_valid`=0, `Y`=0, `onehot`=8'h00, `multi`=0 at both edges.
- **Fixed priority, `mode`=0, `out_ready`=1:**
  - `D`=8'h80 -> next cycle `Y`=0, `onehot`=8'h80, `out_valid`=1, `multi`=0.
  - `D`=8'h01 -> `Y`=7, `onehot`=8'h01.
  - `D`=8'h0C -> `Y`=4, `onehot`=8'h08, `multi`=1.
  - `D`=8'h00 -> `Y`=0, `out_valid`=0.
- **Round-robin rotation, `mode`=1:** `D` held 8'hFF, `out_ready`=1 from reset -> `Y` = 0,1,2,…,7,0 on consecutive cycles; `multi`=1 throughout.
- **Round-robin sparse:** `mode`=1, `D`=8'h81 held -> `Y` alternates 0,7,0,7; `onehot` alternates 8'h80, 8'h01.
- **Backpressure:**
  - `out_ready`=0, `D`=8'h80 loaded (`Y`=0).
  - Then `D`=8'h01 for 3 cycles -> `Y`=0 and `out_valid`=1 held.
  - Raise `out_ready` -> next cycle `Y`=7.
  - In `mode`=1, `ptr` becomes 1 at that accept.
- **Reset mid-operation:**
  - `mode`=1, after an accepted grant with `Y`=3, drive `rst`=0 for 1 cycle -> `out_valid`=0.
  - Then `D`=8'hFF -> `Y`=0 (pointer back to 0).

Source files
------------

// File: rtl/priority_enc_rr_if.sv
`default_nettype none
// ============================================================================
// Module      : priority_enc_rr_if
// Description : Request/result bundle for the registered round-robin
//               priority encoder.
//                 D         - request vector, slot i = D[N-1-i]
//                 mode      - 0 fixed priority, 1 round-robin
//                 out_ready - consumer can take the presented result
//                 Y         - encoded winning slot
//                 onehot    - D reduced to the winning bit only
//                 multi     - more than one request when loaded
//                 out_valid - Y/onehot/multi carry a real result
//               master : request source / result consumer side
//               slave  : encoder side
// Revision    : 1.0 - initial release
// ============================================================================
interface priority_enc_rr_if #(
   parameter int N = 8,
   parameter int W = $clog2(N)
);
   logic [N-1:0] D;
   logic         mode;
   logic         out_ready;
   logic [W-1:0] Y;
   logic [N-1:0] onehot;
   logic         multi;
   logic         out_valid;

   modport master (
      output D,
      output mode,
      output out_ready,
      input  Y,
      input  onehot,
      input  multi,
      input  out_valid
   );

   modport slave (
      input  D,
      input  mode,
      input  out_ready,
      output Y,
      output onehot,
      output multi,
      output out_valid
   );
endinterface
`default_nettype wire

// File: rtl/priority_enc_rr.sv
`default_nettype none
// ============================================================================
// Module      : priority_enc_rr
// Description : Registered N-input priority encoder with fixed-priority or
//               round-robin arbitration and a valid/ready output stage.
//               Slot 0 is the MSB of D. One result register stage; a new
//               request vector is sampled whenever the stage is empty or
//               being accepted. All outputs come straight from flops.
// Ports       : clk  - clock, rising edge
//               rst  - synchronous reset, active low
//               bus  - priority_enc_rr_if.slave (D, mode, out_ready in;
//                      Y, onehot, multi, out_valid out)
// Revision    : 1.0 - initial release
// ============================================================================
module priority_enc_rr #(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  wire logic          clk,
   input  wire logic          rst,
   priority_enc_rr_if.slave   bus
);

   localparam logic [W-1:0] c_last = W'(N - 1);

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   logic [W-1:0] r_y;
   logic [N-1:0] r_onehot;
   logic         r_multi;
   logic         r_valid;
   logic [W-1:0] r_ptr;

   // ---------------------------------------------------------------------
   // Combinational signals
   // ---------------------------------------------------------------------
   logic [N-1:0] w_req_slot;    // requests re-ordered so bit i = slot i
   logic         w_any;
   logic         w_multi;
   logic         w_load;
   logic         w_accept;
   logic [W-1:0] w_ptr_adv;     // pointer value following the presented Y
   logic [W-1:0] w_ptr_eff;     // pointer used by the load this cycle
   logic [W-1:0] w_fixed_idx;
   logic [W-1:0] w_rr_hi_idx;
   logic         w_rr_hi_found;
   logic [W-1:0] w_win;
   logic [N-1:0] w_onehot;

   // Slot reversal and one-hot grant construction. The grant for slot i
   // lands on D bit N-1-i so onehot is a masked copy of D.
   for (genvar i = 0; i < N; i++) begin : g_slot
      localparam logic [W-1:0] c_slot = W'(i);
      assign w_req_slot[i]     = bus.D[N-1-i];
      assign w_onehot[N-1-i]   = w_any & (w_win == c_slot);
   end

   assign w_any    = |bus.D;
   // Clearing the lowest set bit leaves something only if two or more
   // bits were set.
   assign w_multi  = |(bus.D & (bus.D - N'(1)));

   assign w_load   = !r_valid || bus.out_ready;
   assign w_accept = r_valid && bus.out_ready;

   assign w_ptr_adv = (r_y == c_last) ? '0 : (r_y + W'(1));

   // A load that coincides with a round-robin accept must already see the
   // advanced pointer, otherwise a saturated request set would repeat the
   // previous winner instead of rotating every cycle.
   assign w_ptr_eff = (w_accept && bus.mode) ? w_ptr_adv : r_ptr;

   // Round-robin is done as a two-pass search: the lowest requesting slot
   // at or above the pointer wins; if there is none the scan has wrapped,
   // and the winner is simply the lowest requesting slot overall, which is
   // exactly the fixed-priority winner. This handles non-power-of-two N
   // without any modulo arithmetic.
   always_comb begin
      w_fixed_idx   = '0;
      w_rr_hi_idx   = '0;
      w_rr_hi_found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (w_req_slot[i]) begin
            w_fixed_idx = W'(i);
            if (W'(i) >= w_ptr_eff) begin
               w_rr_hi_idx   = W'(i);
               w_rr_hi_found = 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_win = w_fixed_idx;
      if (bus.mode && w_rr_hi_found) begin
         w_win = w_rr_hi_idx;
      end
   end

   // ---------------------------------------------------------------------
   // Result stage and pointer
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_y      <= '0;
         r_onehot <= '0;
         r_multi  <= 1'b0;
         r_valid  <= 1'b0;
         r_ptr    <= '0;
      end else begin
         if (w_accept && bus.mode) begin
            r_ptr <= w_ptr_adv;
         end
         if (w_load) begin
            r_valid  <= w_any;
            r_y      <= w_any ? w_win : '0;
            r_onehot <= w_onehot;
            r_multi  <= w_multi;
         end
      end
   end

   assign bus.Y         = r_y;
   assign bus.onehot    = r_onehot;
   assign bus.multi     = r_multi;
   assign bus.out_valid = r_valid;

   // ---------------------------------------------------------------------
   // Structural invariants of the result stage
   // ---------------------------------------------------------------------
   a_onehot0 : assert property (@(posedge clk) disable iff (!rst)
      $onehot0(r_onehot));

   a_valid_matches_grant : assert property (@(posedge clk) disable iff (!rst)
      r_valid == (r_onehot != '0));

   a_y_in_range : assert property (@(posedge clk) disable iff (!rst)
      r_y <= c_last);

   a_ptr_in_range : assert property (@(posedge clk) disable iff (!rst)
      r_ptr <= c_last);

   a_stall_holds : assert property (@(posedge clk) disable iff (!rst)
      (r_valid && !bus.out_ready) |=>
         ($stable(r_y) && $stable(r_onehot) && $stable(r_multi) && r_valid));

endmodule
`default_nettype wire

// File: tb/tb_priority_enc_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_priority_enc_rr
// Description : Directed self-checking bench for priority_enc_rr, N = 8.
//               Inputs change 1 ns after a rising edge and outputs are
//               sampled at the same point, i.e. after the edge that loaded
//               them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_priority_enc_rr;

   localparam int N = 8;
   localparam int W = $clog2(N);

   logic clk;
   logic rst;

   int n_checks;
   int n_errors;

   priority_enc_rr_if #(.N(N), .W(W)) bus ();

   priority_enc_rr #(.N(N), .W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input int y, input int oh,
                            input int mu, input int v);
      check({tag, ".Y"},         32'(bus.Y),         32'(y));
      check({tag, ".onehot"},    32'(bus.onehot),    32'(oh));
      check({tag, ".multi"},     32'(bus.multi),     32'(mu));
      check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(v));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle reset, leaving rst released afterwards.
   task automatic pulse_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   // Expected round-robin sequence for D = 8'hFF from a reset pointer.
   int rot_y [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
   int sp_y  [4] = '{0, 7, 0, 7};
   int sp_oh [4] = '{8'h80, 8'h01, 8'h80, 8'h01};

   initial begin
      n_checks      = 0;
      n_errors      = 0;
      rst           = 1'b0;
      bus.D         = 8'hFF;
      bus.mode      = 1'b0;
      bus.out_ready = 1'b1;

      // Reset held for two edges with requests present.
      for (int k = 0; k < 2; k++) begin
         tick();
         check_out($sformatf("reset%0d", k), 0, 8'h00, 0, 0);
      end
      rst = 1'b1;

      // Fixed priority.
      bus.D = 8'h80; tick(); check_out("fix_80", 0, 8'h80, 0, 1);
      bus.D = 8'h01; tick(); check_out("fix_01", 7, 8'h01, 0, 1);
      bus.D = 8'h0C; tick(); check_out("fix_0C", 4, 8'h08, 1, 1);
      bus.D = 8'h00; tick(); check_out("fix_00", 0, 8'h00, 0, 0);
      bus.D = 8'h3A; tick(); check_out("fix_3A", 2, 8'h20, 1, 1);

      // Round-robin rotation with every request set.
      pulse_reset();
      bus.mode = 1'b1;
      bus.D    = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         tick();
         check($sformatf("rot%0d.Y", k),     32'(bus.Y),     32'(rot_y[k]));
         check($sformatf("rot%0d.multi", k), 32'(bus.multi), 32'd1);
      end

      // Round-robin with two requests at the extremes.
      pulse_reset();
      bus.D = 8'h81;
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("sp%0d.Y", k),      32'(bus.Y),      32'(sp_y[k]));
         check($sformatf("sp%0d.onehot", k), 32'(bus.onehot), 32'(sp_oh[k]));
      end

      // Backpressure in round-robin mode.
      pulse_reset();
      bus.out_ready = 1'b0;
      bus.D         = 8'h80;
      tick(); check_out("bp_load", 0, 8'h80, 0, 1);
      bus.D = 8'h01;
      for (int k = 0; k < 3; k++) begin
         // Mode flips while stalled must not disturb the held result.
         bus.mode = k[0];
         tick(); check_out($sformatf("bp_hold%0d", k), 0, 8'h80, 0, 1);
      end
      bus.mode      = 1'b1;
      bus.out_ready = 1'b1;
      tick(); check_out("bp_release", 7, 8'h01, 0, 1);
      check("bp_ptr", 32'(dut.r_ptr), 32'd1);

      // Mode change to fixed: slot 0 wins again regardless of pointer.
      bus.mode = 1'b0;
      bus.D    = 8'hC0;
      tick(); check_out("mode_fix", 0, 8'h80, 1, 1);

      // Reset in the middle of round-robin operation.
      pulse_reset();
      bus.mode = 1'b1;
      bus.D    = 8'hFF;
      for (int k = 0; k < 4; k++) tick();
      check("mid_pre.Y", 32'(bus.Y), 32'd3);
      rst = 1'b0;
      tick(); check_out("mid_rst", 0, 8'h00, 0, 0);
      rst = 1'b1;
      tick(); check_out("mid_after", 0, 8'h80, 1, 1);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
